// File: rtl/table_formatter.sv
// table_formatter: prints a count table as "total sep m*n*c sep ..." ASCII bytes over a valid/ready stream.
// Define TABLE_FMT_CRLF_EN to use CR LF as the separator instead of a single space.
module table_formatter #(
    parameter int MAX_DIM = 5,
    parameter int CNT_W   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [MAX_DIM*MAX_DIM*CNT_W-1:0]   info_table,
    output logic                               busy,
    output logic                               done,
    output logic [7:0]                         dout,
    output logic                               dout_valid,
    input  logic                               dout_ready
);
    localparam int N     = MAX_DIM * MAX_DIM;
    localparam int TOT_W = $clog2(N * (2**CNT_W - 1) + 1);
    localparam int IDX_W = $clog2(N);
`ifdef TABLE_FMT_CRLF_EN
    localparam int SEP_N = 2;
`else
    localparam int SEP_N = 1;
`endif
    localparam logic [2:0] TOT_LAST = 3'(2 + SEP_N);
    localparam logic [2:0] ENT_LAST = 3'(4 + SEP_N);

    typedef enum logic [2:0] {IDLE, SUM, BCD, EMIT_TOTAL, SCAN, EMIT_ENTRY, DONE} state_t;

    state_t                             state, state_nxt;
    logic [MAX_DIM*MAX_DIM*CNT_W-1:0]   snap;
    logic [TOT_W-1:0]                   total;
    logic [3:0]                         hund, tens, row, col;
    logic [IDX_W-1:0]                   idx;
    logic [2:0]                         bpos;
    logic [CNT_W-1:0]                   entry;
    logic [9:0]                         tot_w;
    logic                               last_idx, xfer, tot_end, ent_end;

    function automatic logic [7:0] asc(input logic [3:0] v);
        return 8'h30 + {4'h0, v};
    endfunction

    function automatic logic [7:0] sep(input logic second);
`ifdef TABLE_FMT_CRLF_EN
        return second ? 8'h0A : 8'h0D;
`else
        return second ? 8'h20 : 8'h20;
`endif
    endfunction

    assign entry    = snap[int'(idx)*CNT_W +: CNT_W];
    assign tot_w    = 10'(total);
    assign last_idx = idx == IDX_W'(N - 1);
    assign xfer     = dout_valid && dout_ready;
    assign tot_end  = xfer && bpos == TOT_LAST;
    assign ent_end  = xfer && bpos == ENT_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? SUM : IDLE;
            SUM:        state_nxt = last_idx ? BCD : SUM;
            BCD:        state_nxt = tot_w < 10'd10 ? EMIT_TOTAL : BCD;
            EMIT_TOTAL: state_nxt = tot_end ? SCAN : EMIT_TOTAL;
            SCAN:       state_nxt = entry != '0 ? EMIT_ENTRY : (last_idx ? DONE : SCAN);
            EMIT_ENTRY: state_nxt = ent_end ? (last_idx ? DONE : SCAN) : EMIT_ENTRY;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Row/column track idx so the m and n digits need no divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap  <= '0;
            total <= '0;
            hund  <= '0;
            tens  <= '0;
            idx   <= '0;
            row   <= '0;
            col   <= '0;
            bpos  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    snap  <= info_table;
                    total <= '0;
                    hund  <= '0;
                    tens  <= '0;
                    idx   <= '0;
                end
                SUM: begin
                    total <= total + TOT_W'(entry);
                    idx   <= last_idx ? '0 : idx + 1'b1;
                    row   <= '0;
                    col   <= '0;
                end
                BCD: begin
                    if (tot_w >= 10'd100) begin
                        total <= TOT_W'(tot_w - 10'd100);
                        hund  <= hund + 4'd1;
                    end else if (tot_w >= 10'd10) begin
                        total <= TOT_W'(tot_w - 10'd10);
                        tens  <= tens + 4'd1;
                    end else begin
                        bpos  <= hund != '0 ? 3'd0 : (tens != '0 ? 3'd1 : 3'd2);
                    end
                end
                EMIT_TOTAL: if (xfer) bpos <= bpos + 3'd1;
                SCAN: begin
                    if (entry != '0) begin
                        bpos <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        row <= col == 4'(MAX_DIM - 1) ? row + 4'd1 : row;
                        col <= col == 4'(MAX_DIM - 1) ? 4'd0 : col + 4'd1;
                    end
                end
                EMIT_ENTRY: if (ent_end) begin
                    idx <= idx + 1'b1;
                    row <= col == 4'(MAX_DIM - 1) ? row + 4'd1 : row;
                    col <= col == 4'(MAX_DIM - 1) ? 4'd0 : col + 4'd1;
                end else if (xfer) begin
                    bpos <= bpos + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = state != IDLE;
        done       = state == DONE;
        dout_valid = state == EMIT_TOTAL || state == EMIT_ENTRY;
        dout       = 8'h00;
        if (state == EMIT_TOTAL)
            dout = bpos == 3'd0 ? asc(hund) :
                   bpos == 3'd1 ? asc(tens) :
                   bpos == 3'd2 ? asc(tot_w[3:0]) : sep(bpos == 3'd4);
        else if (state == EMIT_ENTRY)
            dout = bpos == 3'd0 ? asc(row + 4'd1) :
                   bpos == 3'd2 ? asc(col + 4'd1) :
                   bpos == 3'd4 ? asc(4'(entry)) :
                   bpos < 3'd4  ? 8'h2A : sep(bpos == 3'd6);
    end
endmodule

// File: tb/tb_table_formatter.sv
// tb_table_formatter: random and directed prints checked against a byte-list reference model.
module tb_table_formatter;
    localparam int D = 5;
    localparam int C = 2;
    localparam int W = D * D * C;

    logic         clk = 0, rst_n = 0, start = 0, dout_ready = 0;
    logic [W-1:0] info_table = '0;
    logic         busy, done, dout_valid;
    logic [7:0]   dout;
    int           errors = 0, checks = 0;
    byte unsigned exp_q[$], got_q[$];

    table_formatter #(.MAX_DIM(D), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .info_table(info_table),
        .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_sep();
`ifdef TABLE_FMT_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h20);
`endif
    endfunction

    function automatic void build_exp(input logic [W-1:0] t);
        int tot = 0;
        exp_q.delete();
        for (int i = 0; i < D * D; i++) tot += int'(t[i*C +: C]);
        if (tot >= 100) exp_q.push_back(byte'(8'h30 + tot / 100));
        if (tot >= 10) exp_q.push_back(byte'(8'h30 + (tot / 10) % 10));
        exp_q.push_back(byte'(8'h30 + tot % 10));
        push_sep();
        for (int i = 0; i < D * D; i++) begin
            int c = int'(t[i*C +: C]);
            if (c != 0) begin
                exp_q.push_back(byte'(8'h30 + i / D + 1));
                exp_q.push_back(8'h2A);
                exp_q.push_back(byte'(8'h30 + i % D + 1));
                exp_q.push_back(8'h2A);
                exp_q.push_back(byte'(8'h30 + c));
                push_sep();
            end
        end
    endfunction

    // mode 0: ready held high, 1: ready toggles 1010..., 2: random ready
    task automatic run_print(input logic [W-1:0] t, input int mode, input int abort_n, input string tag);
        int  dones = 0;
        bit  fin = 0, pv = 0, pr = 0;
        logic [7:0] pd = 0;
        build_exp(t);
        got_q.delete();
        @(negedge clk);
        info_table = t;
        start = 1;
        dout_ready = 0;
        @(negedge clk);
        start = 0;
        info_table = {$urandom, $urandom};
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (abort_n != 0 && got_q.size() == abort_n) begin
                rst_n = 0;
                #1;
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_valid"}, dout_valid, 0);
                check({tag, "_rst_dout"}, dout, 0);
                check({tag, "_rst_nodone"}, dones, 0);
                @(negedge clk);
                rst_n = 1;
                return;
            end
            dout_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom % 2);
            start = (busy && !done) ? ($urandom % 4 == 0) : 1'b0;
            #1;
            if (pv && !pr) begin
                check({tag, "_hold_valid"}, dout_valid, 1);
                check({tag, "_hold_dout"}, dout, pd);
            end
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (done) begin
                dones++;
                fin = 1;
            end
            pv = dout_valid;
            pr = dout_ready;
            pd = dout;
            @(negedge clk);
        end
        start = 0;
        #1;
        check({tag, "_done_cnt"}, dones, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [W-1:0] t;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_dout", dout, 0);
        rst_n = 1;
        t = '0; t[1:0] = 2'd1;
        run_print(t, 0, 0, "entry0");
        run_print('0, 0, 0, "zeros");
        run_print('1, 0, 0, "all3");
        t = '0; t[7*C +: C] = 2'd2;
        run_print(t, 1, 0, "m2n3");
        t = '0; t[24*C +: C] = 2'd2;
        run_print(t, 2, 0, "last");
        run_print('1, 0, 3, "abort");
        run_print('1, 2, 0, "after_abort");
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < D * D; i++)
                t[i*C +: C] = ($urandom % 3 == 0) ? 2'($urandom) : 2'd0;
            run_print(t, 2, 0, $sformatf("rand%0d", k));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
